mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the ECNURVCORE pipeline, directly downstream of the execute stage. It registers the execute result, performs RV64 load/store accesses over a single-request data bus with wait-state support, aligns and sign/zero-extends load data, and hands the register-writeback triple to the writeback stage. While a bus access is outstanding it stalls the upstream pipeline.

## Interface
- XLEN, 64, register/data width; all widths come from `define.v` buses (`BUS_DATA_REG`, `BUS_ADDR_MEM`, `BUS_ADDR_REG`).
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  reset; synchronous and active-high, despite the codebase port name.
- hold_code  in  `BUS_HOLD_CODE`  controller stall; stage freezes when bit `HOLD_MEM_BIT` is set.
- ex_valid_i  in  1  execute stage presents an instruction.
- alu_result_i  in  XLEN  ALU result, or effective address for memory ops.
- data_rs2_i  in  XLEN  store data.
- mem_rd_en_i / mem_wr_en_i  in  1 each  load / store instruction; never both high.
- load_code_i  in  3  funct3: LB=0, LH=1, LW=2, LD=3, LBU=4, LHU=5, LWU=6.
- store_code_i  in  2  SB=0, SH=1, SW=2, SD=3.
- addr_reg_wr_i  in  5  destination register; reg_wr_en_i  in  1  write enable.
- dbus_req_o  out  1  bus request; dbus_we_o  out  1  write.
- dbus_addr_o  out  XLEN  doubleword-aligned address ({addr[63:3],3'b0}).
- dbus_wdata_o  out  64  lane-shifted store data; dbus_strb_o  out  8  byte strobes.
- dbus_ack_i  in  1  access done; dbus_rdata_i  in  64  read data, valid with ack.
- mem_hold_o  out  1  stall request to the pipeline controller.
- wb_valid_o, reg_wr_en_o  out  1; addr_reg_wr_o  out  5; data_reg_wr_o  out  XLEN  writeback outputs.
- misalign_o  out  1  misaligned access flag (see Configuration).

## Operation
- The FSM has three states: IDLE, REQ and DONE.
- **Accept.** An instruction is accepted when ex_valid_i is high, hold is clear and mem_hold_o is low.
- **IDLE.** A non-memory instruction is accepted and registered to the writeback outputs. A memory instruction latches address, data, codes and rd, then moves to REQ.
- **REQ.** dbus_req_o=1, with dbus_addr_o/we/wdata/strb held stable. When dbus_ack_i is sampled high, the aligned result is latched and the FSM moves to DONE.
- **DONE.** wb_valid_o=1 for one cycle. A new instruction may be accepted in the same cycle. The FSM returns to IDLE, or to REQ if the accepted instruction is a memory op.
- mem_hold_o = (state==REQ).
- **Load alignment.**
  - lane = addr[2:0]; the raw value is dbus_rdata_i >> (8*lane).
  - Sign-extend for LB/LH/LW from bit 7/15/31; zero-extend for LBU/LHU/LWU; LD passes through.
- **Store alignment.**
  - dbus_wdata_o = rs2 << (8*lane).
  - dbus_strb_o = (8'h01/03/0F/FF for SB/SH/SW/SD) << lane, truncated to 8 bits.
- Stores force reg_wr_en_o=0.
- **Boundaries.**
  - dbus_ack_i in IDLE or DONE is ignored.
  - Reset in REQ drops dbus_req_o in the next cycle and discards the access.
  - Hold in DONE keeps all writeback outputs and the state stable.
  - Hold in REQ does not block ack capture.

## Timing
- Reset values:
  - All outputs are 0; the FSM is in IDLE.
  - dbus_addr_o, dbus_wdata_o and data_reg_wr_o are all-zero.
- Non-memory op: accepted at edge N, wb outputs valid in cycle N+1. Throughput is 1 per cycle.
- Memory op:
  - Accepted at edge N; dbus_req_o rises in cycle N+1.
  - If ack arrives in cycle N+1+W, wb_valid_o is high in cycle N+2+W.
  - Latency is 2+W cycles.
- Request rule: the request stays asserted, with stable payload, until ack is sampled. At most one access is outstanding.

## Configuration
- **MEM_MISALIGN_EXC_EN defined.**
  - A misaligned access (LH/LHU/SH with addr[0]≠0; LW/LWU/SW with addr[1:0]≠0; LD/SD with addr[2:0]≠0) is not sent to the bus.
  - The FSM goes IDLE→DONE directly, with misalign_o=1, wb_valid_o=1 and reg_wr_en_o=0 in that cycle.
- **MEM_MISALIGN_EXC_EN undefined.**
  - misalign_o is tied to 0 and every access is issued.
  - Bytes whose lanes fall past byte 7 are dropped: strobe is truncated, load upper bits come from the shift.

## Structure
- Shared package / `define.v` holds:
  - load/store code encodings,
  - FSM state encodings,
  - `HOLD_MEM_BIT`,
  - strobe base masks.
- One sub-module, `mem_align`: purely combinational lane shifter with load extension and store strobe/data generation. It is instantiated once, and the FSM and registers stay in `mem_stage`.

## Test plan
- ALU op, alu_result_i=64'h1234, rd=5, reg_wr_en=1 -> next cycle wb_valid_o=1, data_reg_wr_o=64'h1234, addr_reg_wr_o=5, dbus_req_o=0.
- LB at addr 64'h1003, rdata=64'h0000_0000_8000_0000, ack with 2 wait cycles -> dbus_addr_o=64'h1000; mem_hold_o high 3 cycles; data_reg_wr_o=64'hFFFF_FFFF_FFFF_FF80.
- LWU at addr 64'h2004, rdata=64'hDEAD_BEEF_0000_0000 -> data_reg_wr_o=64'h0000_0000_DEAD_BEEF.
- SH at addr 64'h3006, rs2=64'hABCD -> dbus_strb_o=8'hC0, dbus_wdata_o=64'hABCD_0000_0000_0000, reg_wr_en_o=0.
- rst_n asserted in REQ, then ack pulsed -> dbus_req_o=0 next cycle, wb_valid_o stays 0.
- With MEM_MISALIGN_EXC_EN, LW at 64'h4002 -> no dbus_req_o; misalign_o=1 and reg_wr_en_o=0 one cycle after accept.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: widths, hold bit, load/store
// codes, FSM states, strobe base masks and the misalignment check.
package mem_stage_pkg;
  localparam int XLEN         = 64;
  localparam int HOLD_CODE_W  = 5;
  localparam int HOLD_MEM_BIT = 3;

  typedef enum logic [2:0] {
    LD_LB = 3'd0, LD_LH = 3'd1, LD_LW = 3'd2, LD_LD = 3'd3,
    LD_LBU = 3'd4, LD_LHU = 3'd5, LD_LWU = 3'd6
  } load_code_e;

  typedef enum logic [1:0] {
    ST_SB = 2'd0, ST_SH = 2'd1, ST_SW = 2'd2, ST_SD = 2'd3
  } store_code_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2
  } state_e;

  localparam logic [7:0] STRB_B = 8'h01;
  localparam logic [7:0] STRB_H = 8'h03;
  localparam logic [7:0] STRB_W = 8'h0F;
  localparam logic [7:0] STRB_D = 8'hFF;

  // Low two bits of either code give the access size (LBU/LHU/LWU alias LB/LH/LW).
  function automatic logic is_misaligned(input logic is_load, input logic [2:0] lc,
                                         input logic [1:0] sc, input logic [2:0] a);
    logic [1:0] sz;
    sz = is_load ? lc[1:0] : sc;
    case (sz)
      2'd0:    is_misaligned = 1'b0;
      2'd1:    is_misaligned = a[0];
      2'd2:    is_misaligned = |a[1:0];
      default: is_misaligned = |a;
    endcase
  endfunction
endpackage

// File: rtl/mem_stage_align.sv
// Combinational lane shifter: load extraction with sign/zero extension and
// store data/strobe placement for a 64-bit data bus.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  lane_i,
  input  logic [2:0]  load_code_i,
  input  logic [1:0]  store_code_i,
  input  logic [63:0] rdata_i,
  input  logic [63:0] rs2_i,
  output logic [63:0] load_data_o,
  output logic [63:0] wdata_o,
  output logic [7:0]  strb_o
);
  logic [5:0]  sh;
  logic [63:0] raw;
  logic [7:0]  base;

  assign sh = {lane_i, 3'b000};

  always_comb begin
    raw = rdata_i >> sh;
    case (load_code_i)
      LD_LB:   load_data_o = {{56{raw[7]}}, raw[7:0]};
      LD_LH:   load_data_o = {{48{raw[15]}}, raw[15:0]};
      LD_LW:   load_data_o = {{32{raw[31]}}, raw[31:0]};
      LD_LBU:  load_data_o = {56'd0, raw[7:0]};
      LD_LHU:  load_data_o = {48'd0, raw[15:0]};
      LD_LWU:  load_data_o = {32'd0, raw[31:0]};
      default: load_data_o = raw;
    endcase
    case (store_code_i)
      ST_SB:   base = STRB_B;
      ST_SH:   base = STRB_H;
      ST_SW:   base = STRB_W;
      default: base = STRB_D;
    endcase
    // Lanes shifted past byte 7 fall off the 8-bit strobe.
    strb_o  = base << lane_i;
    wdata_o = rs2_i << sh;
  end
endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: registers execute results, runs one load/store at a time
// over the data bus, and drives writeback. MEM_MISALIGN_EXC_EN traps misaligned ops.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [HOLD_CODE_W-1:0] hold_code,
  input  logic                   ex_valid_i,
  input  logic [XLEN-1:0]        alu_result_i,
  input  logic [XLEN-1:0]        data_rs2_i,
  input  logic                   mem_rd_en_i,
  input  logic                   mem_wr_en_i,
  input  logic [2:0]             load_code_i,
  input  logic [1:0]             store_code_i,
  input  logic [4:0]             addr_reg_wr_i,
  input  logic                   reg_wr_en_i,
  output logic                   dbus_req_o,
  output logic                   dbus_we_o,
  output logic [XLEN-1:0]        dbus_addr_o,
  output logic [63:0]            dbus_wdata_o,
  output logic [7:0]             dbus_strb_o,
  input  logic                   dbus_ack_i,
  input  logic [63:0]            dbus_rdata_i,
  output logic                   mem_hold_o,
  output logic                   wb_valid_o,
  output logic                   reg_wr_en_o,
  output logic [4:0]             addr_reg_wr_o,
  output logic [XLEN-1:0]        data_reg_wr_o,
  output logic                   misalign_o
);
  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d, rs2_q, rs2_d;
  logic            is_store_q, is_store_d, rd_wen_q, rd_wen_d;
  logic [2:0]      load_code_q, load_code_d;
  logic [1:0]      store_code_q, store_code_d;
  logic [4:0]      rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic            wb_valid_q, wb_valid_d, wb_wen_q, wb_wen_d, misalign_q, misalign_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            hold, mis, in_req;
  logic [63:0]     load_data, wdata;
  logic [7:0]      strb;

  assign hold   = hold_code[HOLD_MEM_BIT];
  assign in_req = (state_q == S_REQ);

`ifdef MEM_MISALIGN_EXC_EN
  assign mis = is_misaligned(mem_rd_en_i, load_code_i, store_code_i, alu_result_i[2:0]);
`else
  assign mis = 1'b0;
`endif

  mem_align u_align (
    .lane_i      (addr_q[2:0]),
    .load_code_i (load_code_q),
    .store_code_i(store_code_q),
    .rdata_i     (dbus_rdata_i),
    .rs2_i       (rs2_q),
    .load_data_o (load_data),
    .wdata_o     (wdata),
    .strb_o      (strb)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rs2_d        = rs2_q;
    is_store_d   = is_store_q;
    rd_wen_d     = rd_wen_q;
    load_code_d  = load_code_q;
    store_code_d = store_code_q;
    rd_d         = rd_q;
    wb_valid_d   = wb_valid_q;
    wb_wen_d     = wb_wen_q;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    misalign_d   = misalign_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        // Hold freezes everything here, including a pending DONE writeback.
        if (!hold) begin
          state_d    = S_IDLE;
          wb_valid_d = 1'b0;
          misalign_d = 1'b0;
          if (ex_valid_i) begin
            if (mem_rd_en_i || mem_wr_en_i) begin
              addr_d       = alu_result_i;
              rs2_d        = data_rs2_i;
              is_store_d   = mem_wr_en_i;
              rd_wen_d     = reg_wr_en_i & ~mem_wr_en_i;
              load_code_d  = load_code_i;
              store_code_d = store_code_i;
              rd_d         = addr_reg_wr_i;
              if (mis) begin
                state_d    = S_DONE;
                wb_valid_d = 1'b1;
                misalign_d = 1'b1;
                wb_wen_d   = 1'b0;
                wb_rd_d    = addr_reg_wr_i;
                wb_data_d  = '0;
              end else begin
                state_d = S_REQ;
              end
            end else begin
              wb_valid_d = 1'b1;
              wb_wen_d   = reg_wr_en_i;
              wb_rd_d    = addr_reg_wr_i;
              wb_data_d  = alu_result_i;
            end
          end
        end
      end
      S_REQ: begin
        if (dbus_ack_i) begin
          state_d    = S_DONE;
          wb_valid_d = 1'b1;
          wb_wen_d   = rd_wen_q;
          wb_rd_d    = rd_q;
          wb_data_d  = is_store_q ? '0 : load_data;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      rs2_q        <= '0;
      is_store_q   <= 1'b0;
      rd_wen_q     <= 1'b0;
      load_code_q  <= '0;
      store_code_q <= '0;
      rd_q         <= '0;
      wb_valid_q   <= 1'b0;
      wb_wen_q     <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rs2_q        <= rs2_d;
      is_store_q   <= is_store_d;
      rd_wen_q     <= rd_wen_d;
      load_code_q  <= load_code_d;
      store_code_q <= store_code_d;
      rd_q         <= rd_d;
      wb_valid_q   <= wb_valid_d;
      wb_wen_q     <= wb_wen_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      misalign_q   <= misalign_d;
    end
  end

  assign dbus_req_o    = in_req;
  assign dbus_we_o     = in_req & is_store_q;
  assign dbus_addr_o   = {addr_q[XLEN-1:3], 3'b000};
  assign dbus_wdata_o  = wdata;
  assign dbus_strb_o   = dbus_we_o ? strb : 8'h00;
  assign mem_hold_o    = in_req;
  assign wb_valid_o    = wb_valid_q;
  assign reg_wr_en_o   = wb_wen_q;
  assign addr_reg_wr_o = wb_rd_q;
  assign data_reg_wr_o = wb_data_q;
  assign misalign_o    = misalign_q;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table of single ops plus hand-written
// sequences for back-to-back, hold, reset-in-REQ, stray ack and misalignment.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [HOLD_CODE_W-1:0] hold_code;
  logic                   ex_valid_i, mem_rd_en_i, mem_wr_en_i, reg_wr_en_i, dbus_ack_i;
  logic [63:0]            alu_result_i, data_rs2_i, dbus_rdata_i;
  logic [2:0]             load_code_i;
  logic [1:0]             store_code_i;
  logic [4:0]             addr_reg_wr_i;
  logic                   dbus_req_o, dbus_we_o, mem_hold_o, wb_valid_o, reg_wr_en_o, misalign_o;
  logic [63:0]            dbus_addr_o, dbus_wdata_o, data_reg_wr_o;
  logic [7:0]             dbus_strb_o;
  logic [4:0]             addr_reg_wr_o;

  int checks = 0;
  int failures = 0;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .hold_code(hold_code), .ex_valid_i(ex_valid_i),
    .alu_result_i(alu_result_i), .data_rs2_i(data_rs2_i), .mem_rd_en_i(mem_rd_en_i),
    .mem_wr_en_i(mem_wr_en_i), .load_code_i(load_code_i), .store_code_i(store_code_i),
    .addr_reg_wr_i(addr_reg_wr_i), .reg_wr_en_i(reg_wr_en_i), .dbus_req_o(dbus_req_o),
    .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_strb_o(dbus_strb_o), .dbus_ack_i(dbus_ack_i), .dbus_rdata_i(dbus_rdata_i),
    .mem_hold_o(mem_hold_o), .wb_valid_o(wb_valid_o), .reg_wr_en_o(reg_wr_en_o),
    .addr_reg_wr_o(addr_reg_wr_o), .data_reg_wr_o(data_reg_wr_o), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        ld, st;
    logic [2:0]  lc;
    logic [1:0]  sc;
    logic [63:0] addr, rs2, rdata;
    int          waits;
    logic [63:0] exp_addr, exp_data, exp_wdata;
    logic [7:0]  exp_strb;
    logic        exp_wen;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic st, input logic [2:0] lc, input logic [1:0] sc,
                       input logic [63:0] a, input logic [63:0] d, input logic [4:0] rd);
    ex_valid_i = 1'b1; mem_rd_en_i = ld; mem_wr_en_i = st; load_code_i = lc; store_code_i = sc;
    alu_result_i = a; data_rs2_i = d; addr_reg_wr_i = rd; reg_wr_en_i = 1'b1;
  endtask

  task automatic idle_inputs();
    ex_valid_i = 1'b0; mem_rd_en_i = 1'b0; mem_wr_en_i = 1'b0;
  endtask

  // Called at a negedge with the FSM idle; returns at the negedge of the wb cycle.
  task automatic run_vec(input vec_t v, input logic [4:0] rd);
    int hold_cnt;
    drive(v.ld, v.st, v.lc, v.sc, v.addr, v.rs2, rd);
    @(negedge clk);
    idle_inputs();
    if (v.ld || v.st) begin
      hold_cnt = 0;
      chk({v.nm, " req"}, 64'(dbus_req_o), 64'd1);
      chk({v.nm, " addr"}, dbus_addr_o, v.exp_addr);
      chk({v.nm, " we"}, 64'(dbus_we_o), 64'(v.st));
      chk({v.nm, " strb"}, 64'(dbus_strb_o), 64'(v.exp_strb));
      if (v.st) chk({v.nm, " wdata"}, dbus_wdata_o, v.exp_wdata);
      for (int w = 0; w < v.waits; w++) begin
        if (mem_hold_o) hold_cnt++;
        @(negedge clk);
      end
      if (mem_hold_o) hold_cnt++;
      chk({v.nm, " strb stable"}, 64'(dbus_strb_o), 64'(v.exp_strb));
      chk({v.nm, " addr stable"}, dbus_addr_o, v.exp_addr);
      dbus_ack_i = 1'b1; dbus_rdata_i = v.rdata;
      @(negedge clk);
      dbus_ack_i = 1'b0;
      chk({v.nm, " hold cycles"}, 64'(hold_cnt), 64'(v.waits + 1));
    end
    chk({v.nm, " wb_valid"}, 64'(wb_valid_o), 64'd1);
    chk({v.nm, " req low"}, 64'(dbus_req_o), 64'd0);
    chk({v.nm, " rd"}, 64'(addr_reg_wr_o), 64'(rd));
    chk({v.nm, " wen"}, 64'(reg_wr_en_o), 64'(v.exp_wen));
    if (!v.st) chk({v.nm, " data"}, data_reg_wr_o, v.exp_data);
  endtask

  initial begin
    vecs[0]  = '{"ALU",  0,0,3'd0,2'd0, 64'h1234, 64'h0, 64'h0, 0, 64'h0, 64'h1234, 64'h0, 8'h00, 1};
    vecs[1]  = '{"LB",   1,0,3'd0,2'd0, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 2,
                 64'h1000, 64'hFFFF_FFFF_FFFF_FF80, 64'h0, 8'h00, 1};
    vecs[2]  = '{"LWU",  1,0,3'd6,2'd0, 64'h2004, 64'h0, 64'hDEAD_BEEF_0000_0000, 0,
                 64'h2000, 64'h0000_0000_DEAD_BEEF, 64'h0, 8'h00, 1};
    vecs[3]  = '{"SH",   0,1,3'd0,2'd1, 64'h3006, 64'hABCD, 64'h0, 1,
                 64'h3000, 64'h0, 64'hABCD_0000_0000_0000, 8'hC0, 0};
    vecs[4]  = '{"LH",   1,0,3'd1,2'd0, 64'h6002, 64'h0, 64'h0000_0000_8001_0000, 0,
                 64'h6000, 64'hFFFF_FFFF_FFFF_8001, 64'h0, 8'h00, 1};
    vecs[5]  = '{"LHU",  1,0,3'd5,2'd0, 64'h6002, 64'h0, 64'h0000_0000_8001_0000, 1,
                 64'h6000, 64'h0000_0000_0000_8001, 64'h0, 8'h00, 1};
    vecs[6]  = '{"LW",   1,0,3'd2,2'd0, 64'h7004, 64'h0, 64'h8000_0001_0000_0000, 3,
                 64'h7000, 64'hFFFF_FFFF_8000_0001, 64'h0, 8'h00, 1};
    vecs[7]  = '{"LD",   1,0,3'd3,2'd0, 64'h5008, 64'h0, 64'h0123_4567_89AB_CDEF, 0,
                 64'h5008, 64'h0123_4567_89AB_CDEF, 64'h0, 8'h00, 1};
    vecs[8]  = '{"SB",   0,1,3'd0,2'd0, 64'h5005, 64'hFF12, 64'h0, 0,
                 64'h5000, 64'h0, 64'h00FF_1200_0000_0000, 8'h20, 0};
    vecs[9]  = '{"SD",   0,1,3'd0,2'd3, 64'h8000, 64'h1122_3344_5566_7788, 64'h0, 2,
                 64'h8000, 64'h0, 64'h1122_3344_5566_7788, 8'hFF, 0};
    vecs[10] = '{"LBU",  1,0,3'd4,2'd0, 64'h1007, 64'h0, 64'h9A00_0000_0000_0000, 0,
                 64'h1000, 64'h0000_0000_0000_009A, 64'h0, 8'h00, 1};
    vecs[11] = '{"SW",   0,1,3'd0,2'd2, 64'h1004, 64'hCAFE_BABE_DEAD_BEEF, 64'h0, 0,
                 64'h1000, 64'h0, 64'hDEAD_BEEF_0000_0000, 8'hF0, 0};

    rst_n = 1'b1; hold_code = '0; idle_inputs(); load_code_i = '0; store_code_i = '0;
    alu_result_i = '0; data_rs2_i = '0; addr_reg_wr_i = '0; reg_wr_en_i = 1'b0;
    dbus_ack_i = 1'b0; dbus_rdata_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst req", 64'(dbus_req_o), 64'd0);
    chk("rst we", 64'(dbus_we_o), 64'd0);
    chk("rst addr", dbus_addr_o, 64'd0);
    chk("rst wdata", dbus_wdata_o, 64'd0);
    chk("rst strb", 64'(dbus_strb_o), 64'd0);
    chk("rst hold", 64'(mem_hold_o), 64'd0);
    chk("rst wb_valid", 64'(wb_valid_o), 64'd0);
    chk("rst wen", 64'(reg_wr_en_o), 64'd0);
    chk("rst rd", 64'(addr_reg_wr_o), 64'd0);
    chk("rst data", data_reg_wr_o, 64'd0);
    chk("rst misalign", 64'(misalign_o), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], (i == 0) ? 5'd5 : 5'(i + 1));
      @(negedge clk);
      chk({vecs[i].nm, " wb one cycle"}, 64'(wb_valid_o), 64'd0);
    end

    // Back-to-back ALU ops: one per cycle.
    drive(0, 0, 3'd0, 2'd0, 64'hAAAA, 64'h0, 5'd7);
    @(negedge clk);
    chk("b2b first data", data_reg_wr_o, 64'hAAAA);
    drive(0, 0, 3'd0, 2'd0, 64'hBBBB, 64'h0, 5'd8);
    @(negedge clk);
    idle_inputs();
    chk("b2b second data", data_reg_wr_o, 64'hBBBB);
    chk("b2b second valid", 64'(wb_valid_o), 64'd1);
    chk("b2b second rd", 64'(addr_reg_wr_o), 64'd8);
    @(negedge clk);

    // Stray ack while idle is ignored.
    dbus_ack_i = 1'b1; dbus_rdata_i = 64'hFFFF;
    @(negedge clk);
    dbus_ack_i = 1'b0;
    chk("idle ack wb_valid", 64'(wb_valid_o), 64'd0);
    chk("idle ack req", 64'(dbus_req_o), 64'd0);

    // Hold in DONE keeps writeback stable; the queued ALU op then issues.
    drive(1, 0, 3'd3, 2'd0, 64'h9000, 64'h0, 5'd9);
    @(negedge clk);
    idle_inputs();
    dbus_ack_i = 1'b1; dbus_rdata_i = 64'h5555_6666_7777_8888;
    @(negedge clk);
    dbus_ack_i = 1'b0;
    chk("done wb_valid", 64'(wb_valid_o), 64'd1);
    hold_code[HOLD_MEM_BIT] = 1'b1;
    drive(0, 0, 3'd0, 2'd0, 64'h4242, 64'h0, 5'd10);
    @(negedge clk);
    chk("done hold valid", 64'(wb_valid_o), 64'd1);
    chk("done hold data", data_reg_wr_o, 64'h5555_6666_7777_8888);
    chk("done hold rd", 64'(addr_reg_wr_o), 64'd9);
    chk("done hold req", 64'(dbus_req_o), 64'd0);
    hold_code[HOLD_MEM_BIT] = 1'b0;
    @(negedge clk);
    idle_inputs();
    chk("done accept data", data_reg_wr_o, 64'h4242);
    chk("done accept rd", 64'(addr_reg_wr_o), 64'd10);
    @(negedge clk);

    // Hold in REQ does not block ack capture.
    drive(1, 0, 3'd3, 2'd0, 64'hA000, 64'h0, 5'd11);
    @(negedge clk);
    idle_inputs();
    hold_code[HOLD_MEM_BIT] = 1'b1;
    dbus_ack_i = 1'b1; dbus_rdata_i = 64'h0BAD_F00D_0000_1111;
    @(negedge clk);
    dbus_ack_i = 1'b0;
    chk("req hold ack valid", 64'(wb_valid_o), 64'd1);
    chk("req hold ack data", data_reg_wr_o, 64'h0BAD_F00D_0000_1111);
    chk("req hold ack req", 64'(dbus_req_o), 64'd0);
    hold_code[HOLD_MEM_BIT] = 1'b0;
    @(negedge clk);
    chk("req hold release", 64'(wb_valid_o), 64'd0);

    // Reset while in REQ discards the access.
    drive(1, 0, 3'd3, 2'd0, 64'hB000, 64'h0, 5'd12);
    @(negedge clk);
    idle_inputs();
    chk("rst-req req before", 64'(dbus_req_o), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst-req req dropped", 64'(dbus_req_o), 64'd0);
    rst_n = 1'b0;
    dbus_ack_i = 1'b1; dbus_rdata_i = 64'h1;
    @(negedge clk);
    dbus_ack_i = 1'b0;
    chk("rst-req wb_valid", 64'(wb_valid_o), 64'd0);
    chk("rst-req req after", 64'(dbus_req_o), 64'd0);
    @(negedge clk);

    // Misaligned LW at 0x4002.
    drive(1, 0, 3'd2, 2'd0, 64'h4002, 64'h0, 5'd13);
    @(negedge clk);
    idle_inputs();
`ifdef MEM_MISALIGN_EXC_EN
    chk("mis req", 64'(dbus_req_o), 64'd0);
    chk("mis flag", 64'(misalign_o), 64'd1);
    chk("mis wb_valid", 64'(wb_valid_o), 64'd1);
    chk("mis wen", 64'(reg_wr_en_o), 64'd0);
    @(negedge clk);
    chk("mis flag clears", 64'(misalign_o), 64'd0);
`else
    chk("mis req", 64'(dbus_req_o), 64'd1);
    chk("mis addr", dbus_addr_o, 64'h4000);
    chk("mis flag", 64'(misalign_o), 64'd0);
    dbus_ack_i = 1'b1; dbus_rdata_i = 64'h0000_0000_1234_5678;
    @(negedge clk);
    dbus_ack_i = 1'b0;
    chk("mis wb_valid", 64'(wb_valid_o), 64'd1);
    chk("mis data", data_reg_wr_o, 64'h0000_0000_0000_1234);
    chk("mis flag wb", 64'(misalign_o), 64'd0);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
